// File: rtl/ooo_execute_dispatch.sv
// ooo_execute_dispatch
//   Buffers decoded bundles in a small circular FIFO and dispatches the head
//   bundle to one of four functional units (ARITH, MUL, DIV, LOADSTORE).
//   A halt bundle reaching the head latches a sticky halt flag and freezes
//   dispatch until reset.
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   flush               drop every buffered bundle (halt flag survives)
//   dec_valid/ready     decode handshake; dec_* payload, sfu_type, halt bit
//   stall_*             per-unit backpressure to decode
//   fu_valid/fu_ready   one-hot dispatch handshake indexed by sfu_type
//   fu_*                head-entry payload
//   halt                sticky halt flag
//   occupancy           number of valid entries
module ooo_execute_dispatch #(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     flush,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [31:0]              dec_instr,
  input  logic [31:0]              dec_pc,
  input  logic [31:0]              dec_port_a,
  input  logic [31:0]              dec_port_b,
  input  logic [1:0]               dec_sfu_type,
  input  logic                     dec_halt,
  output logic                     stall_arith,
  output logic                     stall_multiply,
  output logic                     stall_divide,
  output logic                     stall_loadstore,
  output logic [3:0]               fu_valid,
  input  logic [3:0]               fu_ready,
  output logic [31:0]              fu_instr,
  output logic [31:0]              fu_pc,
  output logic [31:0]              fu_port_a,
  output logic [31:0]              fu_port_b,
  output logic                     halt,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sfu;
    logic        hlt;
  } bundle_t;

  // Payload storage is never reset; only count/pointers define validity.
  bundle_t        mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           halt_q, halt_d;

  bundle_t        head;
  logic           full, empty, enq, deq, head_go;
  logic [3:0]     stall;

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Readiness ignores dequeue in the same cycle: no accept while full.
  assign dec_ready = !full && !flush;
  assign enq       = dec_valid && dec_ready;

  // A halt bundle at the head is never offered to a unit.
  assign head_go  = !empty && !halt_q && !head.hlt && !flush;
  assign fu_valid = head_go ? (4'b0001 << head.sfu) : 4'b0000;
  assign deq      = |(fu_valid & fu_ready);

  for (genvar u = 0; u < 4; u++) begin : g_stall
    assign stall[u] = full | (!empty && (head.sfu == 2'(u)) && !fu_ready[u]) | halt_q;
  end

  assign stall_arith     = stall[0];
  assign stall_multiply  = stall[1];
  assign stall_divide    = stall[2];
  assign stall_loadstore = stall[3];

  assign fu_instr  = head.instr;
  assign fu_pc     = head.pc;
  assign fu_port_a = head.a;
  assign fu_port_b = head.b;
  assign halt      = halt_q;
  assign occupancy = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (!empty && head.hlt) halt_d = 1'b1;
      if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) mem_q[wr_ptr_q] <= '{instr: dec_instr, pc: dec_pc, a: dec_port_a,
                                  b: dec_port_b, sfu: dec_sfu_type, hlt: dec_halt};
  end

endmodule

// File: tb/tb_ooo_execute_dispatch.sv
// Bench for ooo_execute_dispatch: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_ooo_execute_dispatch;
  localparam int DEPTH = 2;

  logic        CLK, RST, flush, dec_valid, dec_ready, dec_halt, halt;
  logic [31:0] dec_instr, dec_pc, dec_port_a, dec_port_b;
  logic [31:0] fu_instr, fu_pc, fu_port_a, fu_port_b;
  logic [1:0]  dec_sfu_type;
  logic        stall_arith, stall_multiply, stall_divide, stall_loadstore;
  logic [3:0]  fu_valid, fu_ready;
  logic [$clog2(DEPTH):0] occupancy;

  ooo_execute_dispatch #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_port_a(dec_port_a), .dec_port_b(dec_port_b),
    .dec_sfu_type(dec_sfu_type), .dec_halt(dec_halt),
    .stall_arith(stall_arith), .stall_multiply(stall_multiply),
    .stall_divide(stall_divide), .stall_loadstore(stall_loadstore),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_instr(fu_instr), .fu_pc(fu_pc), .fu_port_a(fu_port_a), .fu_port_b(fu_port_b),
    .halt(halt), .occupancy(occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [1:0] t; logic h; } ent_t;
  ent_t        mq[$];
  logic        m_halt;
  logic [31:0] disp[$];

  function automatic logic [3:0] exp_valid();
    if (mq.size() == 0 || m_halt || mq[0].h || flush) return 4'b0000;
    return 4'b0001 << mq[0].t;
  endfunction

  function automatic logic [3:0] exp_stall();
    logic [3:0] s;
    for (int u = 0; u < 4; u++)
      s[u] = (mq.size() == DEPTH) || (mq.size() != 0 && mq[0].t == 2'(u) && !fu_ready[u]) || m_halt;
    return s;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mq.delete();
      m_halt = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      logic do_deq, do_enq;
      do_deq = |(exp_valid() & fu_ready);
      do_enq = dec_valid && (mq.size() < DEPTH);
      if (mq.size() != 0 && mq[0].h) m_halt = 1'b1;
      if (do_deq) void'(mq.pop_front());
      if (do_enq) mq.push_back('{pc: dec_pc, t: dec_sfu_type, h: dec_halt});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (!RST) begin
      logic [3:0] ev;
      ev = exp_valid();
      chk("dec_ready", 32'(dec_ready), 32'((mq.size() < DEPTH) && !flush));
      chk("fu_valid", 32'(fu_valid), 32'(ev));
      chk("halt", 32'(halt), 32'(m_halt));
      chk("occupancy", 32'(occupancy), 32'(mq.size()));
      chk("stalls", 32'({stall_loadstore, stall_divide, stall_multiply, stall_arith}), 32'(exp_stall()));
      if (ev != 4'b0000) begin
        chk("fu_pc", fu_pc, mq[0].pc);
        chk("fu_instr", fu_instr, mq[0].pc ^ 32'hA5A5_0000);
        chk("fu_port_a", fu_port_a, mq[0].pc + 32'd1);
        chk("fu_port_b", fu_port_b, ~mq[0].pc);
      end
      if (|(fu_valid & fu_ready)) disp.push_back(fu_pc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic v, input logic [1:0] t, input logic [31:0] pc, input logic h);
    dec_valid    = v;
    dec_sfu_type = t;
    dec_halt     = h;
    dec_pc       = v ? pc : 32'hDEAD_BEEF;
    dec_instr    = v ? (pc ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    dec_port_a   = v ? (pc + 32'd1) : 32'hDEAD_BEEF;
    dec_port_b   = v ? ~pc : 32'hDEAD_BEEF;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int i, cyc;
    logic acc;
    logic [31:0] exp5 [5];
    RST = 1'b1; flush = 1'b0; fu_ready = 4'b0000;
    put(1'b0, 2'd0, 32'h0, 1'b0);
    #3;
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ready", 32'(dec_ready), 32'd1);
    chk("rst_fu_valid", 32'(fu_valid), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_stalls", 32'({stall_loadstore, stall_divide, stall_multiply, stall_arith}), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // single ARITH bundle
    fu_ready = 4'b1111;
    put(1'b1, 2'd0, 32'h100, 1'b0); #1;
    chk("no_fallthru", 32'(fu_valid), 32'd0);
    tick(); put(1'b0, 2'd0, 32'h0, 1'b0); #1;
    chk("arith_valid", 32'(fu_valid), 32'h1);
    chk("arith_pc", fu_pc, 32'h100);
    tick();
    chk("arith_drained", 32'(occupancy), 32'd0);

    // fill with MUL while MUL unit is busy
    fu_ready = 4'b1101;
    put(1'b1, 2'd1, 32'h200, 1'b0); tick();
    put(1'b1, 2'd1, 32'h204, 1'b0); tick();
    put(1'b1, 2'd1, 32'h208, 1'b0); #1;
    chk("full_occ", 32'(occupancy), 32'd2);
    chk("full_ready", 32'(dec_ready), 32'd0);
    chk("full_stalls", 32'({stall_loadstore, stall_divide, stall_multiply, stall_arith}), 32'hF);
    tick();
    chk("full_reject", 32'(occupancy), 32'd2);

    // full + dequeue: no enqueue; then simultaneous enq/deq
    fu_ready = 4'b1111; #1;
    chk("full_deq_valid", 32'(fu_valid), 32'h2);
    chk("full_deq_pc", fu_pc, 32'h200);
    chk("full_deq_ready", 32'(dec_ready), 32'd0);
    tick();
    chk("after_deq_occ", 32'(occupancy), 32'd1);
    chk("after_deq_pc", fu_pc, 32'h204);
    chk("after_deq_ready", 32'(dec_ready), 32'd1);
    tick();
    chk("enqdeq_occ", 32'(occupancy), 32'd1);
    chk("enqdeq_pc", fu_pc, 32'h208);
    put(1'b0, 2'd0, 32'h0, 1'b0); tick();
    chk("enqdeq_drained", 32'(occupancy), 32'd0);

    // five bundles through with random readiness: order must hold across wrap
    disp.delete();
    i = 0; cyc = 0;
    while (i < 5 && cyc < 200) begin
      fu_ready = 4'($urandom_range(0, 15));
      put(1'b1, 2'(i % 4), 32'h300 + 32'(4 * i), 1'b0);
      acc = (mq.size() < DEPTH);
      tick();
      if (acc) i++;
      cyc++;
    end
    chk("wrap_enq_budget", 32'(i), 32'd5);
    put(1'b0, 2'd0, 32'h0, 1'b0);
    fu_ready = 4'b1111;
    cyc = 0;
    while (mq.size() != 0 && cyc < 50) begin tick(); cyc++; end
    chk("wrap_drain_occ", 32'(occupancy), 32'd0);
    chk("wrap_count", 32'(disp.size()), 32'd5);
    exp5 = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h310};
    for (int k = 0; k < 5; k++)
      chk($sformatf("wrap_order%0d", k), (k < disp.size()) ? disp[k] : 32'hFFFF_FFFF, exp5[k]);

    // DIV then halt bundle, then flush
    put(1'b1, 2'd2, 32'h400, 1'b0); tick();
    put(1'b1, 2'd0, 32'h404, 1'b1); #1;
    chk("div_valid", 32'(fu_valid), 32'h4);
    chk("div_pc", fu_pc, 32'h400);
    tick(); put(1'b0, 2'd0, 32'h0, 1'b0); #1;
    chk("halt_head_valid", 32'(fu_valid), 32'd0);
    chk("halt_not_yet", 32'(halt), 32'd0);
    tick();
    chk("halt_set", 32'(halt), 32'd1);
    chk("halt_valid", 32'(fu_valid), 32'd0);
    chk("halt_occ", 32'(occupancy), 32'd1);
    chk("halt_stalls", 32'({stall_loadstore, stall_divide, stall_multiply, stall_arith}), 32'hF);
    put(1'b1, 2'd0, 32'h408, 1'b0); #1;
    chk("halt_enq_ready", 32'(dec_ready), 32'd1);
    tick(); put(1'b0, 2'd0, 32'h0, 1'b0);
    chk("halt_occ2", 32'(occupancy), 32'd2);
    flush = 1'b1; #1;
    chk("flush_valid", 32'(fu_valid), 32'd0);
    chk("flush_ready", 32'(dec_ready), 32'd0);
    tick(); flush = 1'b0; #1;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_keeps_halt", 32'(halt), 32'd1);

    // refill, then asynchronous reset between edges
    fu_ready = 4'b0000;
    put(1'b1, 2'd0, 32'h600, 1'b0); tick();
    put(1'b1, 2'd0, 32'h604, 1'b0); tick();
    put(1'b0, 2'd0, 32'h0, 1'b0); #1;
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    chk("pre_rst_halt", 32'(halt), 32'd1);
    #1 RST = 1'b1; #1;
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_valid", 32'(fu_valid), 32'd0);
    chk("arst_halt", 32'(halt), 32'd0);
    chk("arst_ready", 32'(dec_ready), 32'd1);
    RST = 1'b0;
    tick();
    fu_ready = 4'b1111;
    put(1'b1, 2'd3, 32'h500, 1'b0); tick();
    put(1'b0, 2'd0, 32'h0, 1'b0); #1;
    chk("post_rst_valid", 32'(fu_valid), 32'h8);
    chk("post_rst_pc", fu_pc, 32'h500);
    tick();
    chk("post_rst_drained", 32'(occupancy), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ooo_execute_dispatch.md
OOO_EXECUTE_DISPATCH -- requirements
Module: ooo_execute_dispatch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of decode-bundle buffer entries; legal values are powers of two, 2 or greater.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port flush, input, 1 bit: discard all buffered bundles.
REQ-005 SHALL have port dec_valid, input, 1 bit: the decode stage is presenting a bundle.
REQ-006 SHALL have port dec_ready, output, 1 bit: the buffer can accept a bundle this cycle.
REQ-007 SHALL have ports dec_instr, dec_pc, dec_port_a, dec_port_b, input, 32 bits each: bundle payload.
REQ-008 SHALL have port dec_sfu_type, input, 2 bits: target unit; 0=ARITH, 1=MUL, 2=DIV, 3=LOADSTORE.
REQ-009 SHALL have port dec_halt, input, 1 bit: the bundle is a halt instruction.
REQ-010 SHALL have ports stall_arith, stall_multiply, stall_divide, stall_loadstore, output, 1 bit each: per-unit backpressure to decode.
REQ-011 SHALL have port fu_valid, output, 4 bits, one-hot, indexed by sfu_type: dispatch request.
REQ-012 SHALL have port fu_ready, input, 4 bits, indexed by sfu_type: the unit accepts a dispatch.
REQ-013 SHALL have ports fu_instr, fu_pc, fu_port_a, fu_port_b, output, 32 bits each: head-entry payload.
REQ-014 SHALL have port halt, output, 1 bit: sticky flag, set once a halt bundle has reached the head.
REQ-015 SHALL have port occupancy, output, $clog2(DEPTH)+1 bits: number of valid entries.

Function
REQ-016 SHALL implement a circular FIFO with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and a separate count.
REQ-017 SHALL drive dec_ready = (count != DEPTH) and not flush.
REQ-018 SHALL enqueue on a cycle where dec_valid and dec_ready are both high; the bundle becomes visible at the head no earlier than the next cycle, so there is no fall-through.
REQ-019 SHALL NOT accept an enqueue when full, even if a dequeue happens in the same cycle.
REQ-020 SHALL, when the buffer is non-empty, halt=0 and the head's halt bit=0, assert only fu_valid[head.sfu_type]; it SHALL drive fu_valid=0 in every other case.
REQ-021 SHALL drive fu_* payload outputs from the head entry at all times; their values are don't-care when fu_valid=0.
REQ-022 SHALL dequeue on a cycle where fu_valid[t] and fu_ready[t] are both high, and advance the read pointer.
REQ-023 SHALL, on a cycle with both an enqueue and a dequeue, leave count unchanged and advance both pointers.
REQ-024 SHALL drive stall_<unit> = full, OR (non-empty AND head.sfu_type == unit AND fu_ready[unit] == 0), OR halt.
REQ-025 SHALL, when the head entry has halt bit=1 and flush=0, set halt on the next edge; the head is never dispatched and the buffer stops dequeuing.
REQ-026 SHALL keep halt set until RST; flush SHALL NOT clear halt.
REQ-027 SHALL give flush priority over enqueue and dequeue: on the next edge, count=0 and both pointers=0; during the flush cycle, fu_valid=0 and dec_ready=0.
REQ-028 SHALL drive occupancy = count.
REQ-029 SHALL ignore payload inputs whenever dec_valid=0.

Reset
REQ-030 SHALL, while RST=1 (asynchronously), force count=0, both pointers=0, halt=0, fu_valid=0, and occupancy=0.
REQ-031 SHALL drive dec_ready=1 and all stall outputs=0 after reset, until the first enqueue.
REQ-032 SHALL, on reset asserted mid-transfer, discard all entries; the first bundle accepted after reset SHALL be the first dispatched.
REQ-033 SHALL NOT require payload storage to be reset; its contents are don't-care while invalid.

Verification
REQ-034 SHALL cover: enqueue ARITH bundle with pc=0x100, fu_ready=4'b1111 -> next cycle fu_valid=4'b0001 and fu_pc=0x100, then occupancy=0.
REQ-035 SHALL cover: DEPTH=2, enqueue two MUL bundles with fu_ready[1]=0 -> occupancy=2, dec_ready=0, and all four stalls=1; a third dec_valid is not accepted.
REQ-036 SHALL cover: full buffer, fu_ready[1]=1 together with dec_valid=1 -> one dequeue and no enqueue (occupancy=1); then enqueue and dequeue in the same cycle -> occupancy stays 1.
REQ-037 SHALL cover: push 5 bundles through a DEPTH=2 buffer with random fu_ready -> dispatch order equals enqueue order, showing correct pointer wrap.
REQ-038 SHALL cover: enqueue DIV then a halt bundle -> DIV dispatched, halt=1 the cycle after the halt bundle reaches the head, fu_valid stays 0; flush -> occupancy=0 and halt stays 1.
REQ-039 SHALL cover: RST asserted asynchronously with occupancy=2 -> occupancy=0, fu_valid=0 and halt=0 immediately, without waiting for a clock edge.
